miner_rx_assembler: RTL and testbench

MINER_RX_ASSEMBLER -- requirements
Module: miner_rx_assembler

---
 rtl/miner_pkg.sv | 16 +
 rtl/miner_rx_timer.sv | 40 ++++
 rtl/miner_rx_assembler.sv | 125 ++++++++++++
 tb/tb_miner_rx_assembler.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/miner_pkg.sv
// miner_pkg: constants and FSM state type shared by the miner receive path.
package miner_pkg;

    localparam int FRAME_BYTES = 108;
    localparam int RX_BITS     = 864;
    localparam int HDR_BITS    = 608;
    localparam int TGT_BITS    = 256;
    localparam int CNT_W       = 7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } rx_state_e;

endpackage

// File: rtl/miner_rx_timer.sv
// miner_rx_timer: idle-cycle counter for a frame in progress.
// 'expired' flags the idle cycle that brings the count to TIMEOUT_CYCLES,
// so the frame is dropped on the edge that ends that cycle.
module miner_rx_timer #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear wins, otherwise count idle cycles and saturate.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != CW'(TIMEOUT_CYCLES))) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Idle counter register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = enable && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/miner_rx_assembler.sv
// miner_rx_assembler: collects 108 serial bytes (MSB first) into one
// 864-bit work unit {block header, target} for the miner core.
// Optional idle-timeout abort is enabled with macro MINER_RX_TIMEOUT_EN.
module miner_rx_assembler
    import miner_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic [7:0]         byte_in,
    input  logic               byte_valid,
    output logic               byte_ready,
    output logic [RX_BITS-1:0] rx_data,
    output logic               data_ready,
    output logic               frame_error
);

    if ((TIMEOUT_CYCLES < 1) || (HDR_BITS + TGT_BITS != RX_BITS)) begin : g_param_check
        $error("miner_rx_assembler: invalid TIMEOUT_CYCLES or frame layout");
    end

    rx_state_e          state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [RX_BITS-1:0] staging_q;
    logic [RX_BITS-1:0] staging_d;
    logic [RX_BITS-1:0] rx_data_q;
    logic               data_ready_q;
    logic               accept;
    logic               last_byte;
    logic               abort;

    // DONE is the only state that refuses bytes; a pending byte waits there.
    assign byte_ready = (state_q != DONE);
    assign accept     = byte_valid && byte_ready;
    assign last_byte  = (cnt_q == CNT_W'(FRAME_BYTES - 1));

    // Shifting in from the bottom leaves the first byte at the top after 108 bytes.
    assign staging_d  = {staging_q[RX_BITS-9:0], byte_in};

    // Frame FSM: byte count, staging shift register and output capture.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            staging_q    <= '0;
            rx_data_q    <= '0;
            data_ready_q <= 1'b0;
        end else begin
            data_ready_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        staging_q <= staging_d;
                        cnt_q     <= CNT_W'(1);
                        state_q   <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        staging_q <= staging_d;
                        if (last_byte) begin
                            // Counter parks at 107 through DONE, cleared on return to IDLE.
                            rx_data_q    <= staging_d;
                            data_ready_q <= 1'b1;
                            state_q      <= DONE;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end else if (abort) begin
                        // Partial frame dropped; rx_data keeps the last good frame.
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end
                end
                DONE: begin
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rx_data    = rx_data_q;
    assign data_ready = data_ready_q;

`ifdef MINER_RX_TIMEOUT_EN
    logic timer_clear;
    logic timer_enable;
    logic frame_error_q;

    // An accepted byte always clears the timer, so it beats a coincident expiry.
    assign timer_enable = (state_q == COLLECT) && !accept;
    assign timer_clear  = (state_q != COLLECT) || accept;

    miner_rx_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .n_rst  (n_rst),
        .clear  (timer_clear),
        .enable (timer_enable),
        .expired(abort)
    );

    // One-cycle error pulse following the abort edge.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            frame_error_q <= 1'b0;
        end else begin
            frame_error_q <= abort;
        end
    end

    assign frame_error = frame_error_q;
`else
    assign abort       = 1'b0;
    assign frame_error = 1'b0;
`endif

endmodule

// File: tb/tb_miner_rx_assembler.sv
// tb_miner_rx_assembler: directed bench for the 108-byte frame assembler.
// Timeout scenarios apply when MINER_RX_TIMEOUT_EN is defined (TIMEOUT_CYCLES=8).
module tb_miner_rx_assembler;

    localparam int TO = 8;

    logic         clk = 1'b0;
    logic         n_rst = 1'b0;
    logic [7:0]   byte_in = 8'h00;
    logic         byte_valid = 1'b0;
    logic         byte_ready;
    logic [863:0] rx_data;
    logic         data_ready;
    logic         frame_error;

    int total = 0;
    int bad = 0;
    int dr_cnt = 0;
    int fe_cnt = 0;
    int w;
    int dr_exp_total;

    miner_rx_assembler #(
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .rx_data    (rx_data),
        .data_ready (data_ready),
        .frame_error(frame_error)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled on the inactive edge.
    always @(negedge clk) begin
        if (data_ready === 1'b1) dr_cnt++;
        if (frame_error === 1'b1) fe_cnt++;
    end

    task automatic chk(input string tag, input logic [863:0] obs, input logic [863:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Byte i of test frame f; frame 0 is simply 0x00..0x6B.
    function automatic logic [7:0] fb(input int f, input int i);
        return 8'((i * (2 * f + 1) + f * 37) & 255);
    endfunction

    function automatic logic [863:0] frame_exp(input int f);
        logic [863:0] v;
        v = '0;
        for (int i = 0; i < 108; i++) v = {v[855:0], fb(f, i)};
        return v;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one byte and return 1 ns after the edge that accepts it.
    task automatic send_byte(input logic [7:0] b, output int waits);
        waits = 0;
        byte_in = b;
        byte_valid = 1'b1;
        while (byte_ready !== 1'b1 && waits < 4) begin
            tick(1);
            waits++;
        end
        if (byte_ready !== 1'b1) chk("accept_bound", {863'd0, byte_ready}, 864'd1);
        tick(1);
    endtask

    task automatic send_frame(input int f, input int first, input int last);
        int ww;
        for (int i = first; i <= last; i++) send_byte(fb(f, i), ww);
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_byte_ready", byte_ready, 1);
        chk("rst_data_ready", data_ready, 0);
        chk("rst_frame_error", frame_error, 0);
        chk("rst_rx_data", rx_data, 0);
        tick(2);
        n_rst = 1'b1;
        tick(1);

        // Frame A: 0x00..0x6B back-to-back
        send_frame(0, 0, 106);
        chk("a_no_early_dr", dr_cnt, 0);
        send_byte(fb(0, 107), w);
        byte_valid = 1'b0;
        chk("a_data_ready", data_ready, 1);
        chk("a_byte_ready_done", byte_ready, 0);
        chk("a_rx_data", rx_data, frame_exp(0));
        chk("a_top_byte", rx_data[863:856], 8'h00);
        chk("a_low_byte", rx_data[7:0], 8'h6B);
        tick(1);
        chk("a_dr_pulse_end", data_ready, 0);
        chk("a_byte_ready_back", byte_ready, 1);
        chk("a_dr_count", dr_cnt, 1);

        // Frames B and C with byte_valid held across the boundary
        send_frame(1, 0, 107);
        chk("b_data_ready", data_ready, 1);
        chk("b_rx_data", rx_data, frame_exp(1));
        send_byte(fb(2, 0), w);
        chk("c_first_byte_wait", w, 1);
        send_frame(2, 1, 107);
        byte_valid = 1'b0;
        chk("c_data_ready", data_ready, 1);
        chk("c_rx_data", rx_data, frame_exp(2));
        tick(1);
        chk("bc_dr_count", dr_cnt, 3);

        // Hold: 50 bytes of frame D leave frame C on rx_data
        send_frame(3, 0, 49);
        chk("hold_rx_data", rx_data, frame_exp(2));
        chk("hold_data_ready", data_ready, 0);
        chk("hold_dr_count", dr_cnt, 3);

        // Mid-frame reset after byte 60
        send_frame(3, 50, 59);
        byte_valid = 1'b0;
        n_rst = 1'b0;
        #1;
        chk("mr_rst_rx_data", rx_data, 0);
        chk("mr_rst_byte_ready", byte_ready, 1);
        chk("mr_rst_data_ready", data_ready, 0);
        tick(2);
        n_rst = 1'b1;
        tick(1);
        send_frame(4, 0, 106);
        chk("mr_no_early_dr", dr_cnt, 3);
        send_byte(fb(4, 107), w);
        byte_valid = 1'b0;
        chk("mr_data_ready", data_ready, 1);
        chk("mr_rx_data", rx_data, frame_exp(4));
        tick(1);
        chk("mr_dr_count", dr_cnt, 4);
        chk("mr_no_frame_error", fe_cnt, 0);

`ifdef MINER_RX_TIMEOUT_EN
        // Timeout: 10 bytes then 8 idle cycles
        send_frame(5, 0, 9);
        byte_valid = 1'b0;
        tick(TO - 1);
        chk("to_not_yet", frame_error, 0);
        tick(1);
        chk("to_frame_error", frame_error, 1);
        chk("to_rx_kept", rx_data, frame_exp(4));
        tick(1);
        chk("to_pulse_end", frame_error, 0);
        chk("to_fe_count", fe_cnt, 1);
        send_frame(6, 0, 107);
        byte_valid = 1'b0;
        chk("to_next_data_ready", data_ready, 1);
        chk("to_next_rx_data", rx_data, frame_exp(6));
        tick(1);

        // Race: byte accepted on the expiry cycle
        send_frame(7, 0, 9);
        byte_valid = 1'b0;
        tick(TO - 1);
        send_frame(7, 10, 107);
        byte_valid = 1'b0;
        chk("race_fe_count", fe_cnt, 1);
        chk("race_data_ready", data_ready, 1);
        chk("race_rx_data", rx_data, frame_exp(7));
        tick(1);
        dr_exp_total = 6;
`else
        // No timeout: a long stall keeps the frame open
        send_frame(7, 0, 9);
        byte_valid = 1'b0;
        tick(3 * TO);
        chk("nto_frame_error", frame_error, 0);
        chk("nto_fe_count", fe_cnt, 0);
        send_frame(7, 10, 107);
        byte_valid = 1'b0;
        chk("nto_data_ready", data_ready, 1);
        chk("nto_rx_data", rx_data, frame_exp(7));
        tick(1);
        dr_exp_total = 5;
`endif

        chk("dr_total", dr_cnt, dr_exp_total);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
